// File: rtl/dbg_pkg.sv
// Shared encodings for the CPU run-control sequencer: command opcodes,
// halt causes and the sequencer state enum.
package dbg_pkg;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_RUN_N = 2'd3;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_CMD   = 2'd1;
  localparam logic [1:0] CAUSE_BREAK = 2'd2;
  localparam logic [1:0] CAUSE_COUNT = 2'd3;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RUNN   = 2'd3
  } state_t;

endpackage

// File: rtl/dbg_bp_match.sv
// Instruction-address breakpoint comparator with a one-shot skip so that
// resuming from a breakpoint does not immediately re-hit the same address.
module dbg_bp_match #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] iaddr,
  input  logic          skip_set,
  input  logic          ce,
  output logic          bp_hit
);

  logic bp_skip;

  // skip_set only fires in HALTED (ce=0), so the two updates never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_skip <= 1'b0;
    end else if (skip_set) begin
      bp_skip <= 1'b1;
    end else if (ce) begin
      bp_skip <= 1'b0;
    end
  end

  assign bp_hit = bp_en & (iaddr == bp_addr) & ~bp_skip;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control sequencer: gates the CPU clock enable under halt/step/run/run-N
// commands and breakpoints, and exports halt cause, cycle count and PC snapshot.
module cpu_debug_ctrl
  import dbg_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int YW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  output logic          cmd_ready,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] iaddr,
  output logic          cpu_ce,
  output logic          halted,
  output logic [1:0]    halt_cause,
  output logic [YW-1:0] cycle_cnt,
  output logic [AW-1:0] snap_iaddr
);

  state_t        state, state_next;
  logic [1:0]    cause_next;
  logic [CW-1:0] remaining, rem_next;
  logic          skip_set;
  logic          bp_hit;
  logic          accept;

  dbg_bp_match #(.AW(AW)) u_bp (
    .clk      (clk),
    .reset    (reset),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .iaddr    (iaddr),
    .skip_set (skip_set),
    .ce       (cpu_ce),
    .bp_hit   (bp_hit)
  );

  // Handshake: a command is taken on a clock edge where cmd_valid && cmd_ready;
  // cmd_ready only drops during the single STEP cycle.
  assign cmd_ready = (state != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign halted    = (state == ST_HALTED);

  always_comb begin
    cpu_ce = 1'b0;
    if (!reset) begin
      case (state)
        ST_STEP: cpu_ce = 1'b1;
        ST_RUN,
        ST_RUNN: cpu_ce = ~bp_hit;
        default: cpu_ce = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    cause_next = halt_cause;
    rem_next   = remaining;
    skip_set   = 1'b0;
    case (state)
      ST_HALTED: begin
        if (accept) begin
          case (cmd_op)
            OP_STEP: begin
              state_next = ST_STEP;
              skip_set   = (halt_cause == CAUSE_BREAK);
            end
            OP_RUN: begin
              state_next = ST_RUN;
              skip_set   = (halt_cause == CAUSE_BREAK);
            end
            OP_RUN_N: begin
              if (cmd_count != '0) begin
                state_next = ST_RUNN;
                rem_next   = cmd_count;
                skip_set   = (halt_cause == CAUSE_BREAK);
              end else begin
                cause_next = CAUSE_COUNT;
              end
            end
            default: cause_next = CAUSE_CMD;
          endcase
        end
      end
      ST_STEP: begin
        state_next = ST_HALTED;
        cause_next = CAUSE_CMD;
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_BREAK;
        end else if (accept && cmd_op == OP_HALT) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_CMD;
        end
      end
      ST_RUNN: begin
        // bp_hit keeps cpu_ce low, which also suppresses the decrement.
        if (cpu_ce) rem_next = remaining - 1'b1;
        if (bp_hit) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_BREAK;
        end else if (accept && cmd_op == OP_HALT) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_CMD;
        end else if (remaining == CW'(1)) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_COUNT;
        end
      end
      default: state_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HALTED;
      halt_cause <= CAUSE_RESET;
      remaining  <= '0;
    end else begin
      state      <= state_next;
      halt_cause <= cause_next;
      remaining  <= rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      snap_iaddr <= '0;
    end else begin
      if (cpu_ce && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == ST_HALTED) snap_iaddr <= iaddr;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: a PC model advances by 4 on cpu_ce, and each halt
// event is scored against an expected {halt_cause, cycle_cnt} queue.
module tb_cpu_debug_ctrl;
  import dbg_pkg::*;

  localparam int AW = 32;
  localparam int CW = 16;
  localparam int YW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          cmd_ready;
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic [AW-1:0] iaddr;
  logic          cpu_ce;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [YW-1:0] cycle_cnt;
  logic [AW-1:0] snap_iaddr;

  int n_checks = 0;
  int n_errors = 0;
  int ce_total = 0;
  int ce0;
  logic ce_s;
  logic halted_prev = 1'b1;
  logic [AW-1:0] pc;
  logic [33:0] exp_q[$];

  cpu_debug_ctrl #(.AW(AW), .CW(CW), .YW(YW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_ready  (cmd_ready),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .iaddr      (iaddr),
    .cpu_ce     (cpu_ce),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .snap_iaddr (snap_iaddr)
  );

  // clock / reset / CPU model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
    if (cpu_ce === 1'b1) ce_total <= ce_total + 1;
  end
  assign iaddr = pc;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [CW-1:0] cnt, output logic ce_at);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    ce_at     = cpu_ce;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ce", cpu_ce, 0);
    check("rst_halted", halted, 1);
    check("rst_cause", halt_cause, CAUSE_RESET);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_snap", snap_iaddr, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
  endtask

  // scoreboard: each rising edge of halted consumes one expectation
  always @(negedge clk) begin
    if (halted === 1'b1 && halted_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_halt", 1, 0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("sb_halt_cause", halt_cause, e[33:32]);
        check("sb_cycle_cnt", cycle_cnt, e[31:0]);
      end
    end
    halted_prev = halted;
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HALT; cmd_count = '0;
    bp_en = 1'b0; bp_addr = '0;
    do_reset();

    // single step
    ce0 = ce_total;
    exp_q.push_back({CAUSE_CMD, 32'd1});
    issue(OP_STEP, 16'd0, ce_s);
    check("step_ce_at_accept", ce_s, 0);
    @(negedge clk);
    check("step_ce_t1", cpu_ce, 1);
    check("step_ready_low", cmd_ready, 0);
    check("step_not_halted", halted, 0);
    @(negedge clk);
    check("step_ce_t2", cpu_ce, 0);
    check("step_halted_t2", halted, 1);
    @(negedge clk);
    check("step_snap", snap_iaddr, 32'h4);
    check("step_ce_count", ce_total - ce0, 1);

    // run-N of 5, then HALT and RUN_N 0 while halted
    ce0 = ce_total;
    exp_q.push_back({CAUSE_COUNT, 32'd6});
    issue(OP_RUN_N, 16'd5, ce_s);
    wait_halted(50);
    check("runn5_ce_count", ce_total - ce0, 5);
    issue(OP_HALT, 16'd0, ce_s);
    @(negedge clk);
    check("halt_idle_cause", halt_cause, CAUSE_CMD);
    ce0 = ce_total;
    issue(OP_RUN_N, 16'd0, ce_s);
    repeat (3) @(negedge clk);
    check("runn0_cause", halt_cause, CAUSE_COUNT);
    check("runn0_halted", halted, 1);
    check("runn0_no_ce", ce_total - ce0, 0);

    // breakpoint at 0x10, then resume past it
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    ce0 = ce_total;
    exp_q.push_back({CAUSE_BREAK, 32'd4});
    issue(OP_RUN, 16'd0, ce_s);
    wait_halted(50);
    check("bp_pc", pc, 32'h10);
    check("bp_ce_count", ce_total - ce0, 4);
    @(negedge clk);
    check("bp_snap", snap_iaddr, 32'h10);
    ce0 = ce_total;
    exp_q.push_back({CAUSE_CMD, 32'd14});
    issue(OP_RUN, 16'd0, ce_s);
    repeat (9) @(negedge clk);
    check("bp_resume_running", halted, 0);
    issue(OP_HALT, 16'd0, ce_s);
    check("bp_resume_ce_at_halt", ce_s, 1);
    wait_halted(5);
    check("bp_resume_pc", pc, 32'h38);
    check("bp_resume_ce_count", ce_total - ce0, 10);
    bp_en = 1'b0;

    // RUN, ignored STEP, HALT accepted on the 7th execution cycle
    ce0 = ce_total;
    exp_q.push_back({CAUSE_CMD, 32'd21});
    issue(OP_RUN, 16'd0, ce_s);
    repeat (2) @(negedge clk);
    issue(OP_STEP, 16'd0, ce_s);
    repeat (3) @(negedge clk);
    check("run_still_running", halted, 0);
    issue(OP_HALT, 16'd0, ce_s);
    check("run_ce_at_halt", ce_s, 1);
    @(negedge clk);
    check("run_halted_next", halted, 1);
    check("run_ce_count", ce_total - ce0, 7);

    // RUN_N 3 with a breakpoint on the 3rd fetch
    bp_addr = pc + 32'd8;
    bp_en = 1'b1;
    ce0 = ce_total;
    exp_q.push_back({CAUSE_BREAK, 32'd23});
    issue(OP_RUN_N, 16'd3, ce_s);
    wait_halted(20);
    check("runn_bp_pc", pc, bp_addr);
    check("runn_bp_ce_count", ce_total - ce0, 2);
    bp_en = 1'b0;

    // reset asserted mid-run
    issue(OP_RUN, 16'd0, ce_s);
    repeat (3) @(negedge clk);
    exp_q.push_back({CAUSE_RESET, 32'd0});
    reset = 1'b1;
    #1 check("reset_ce_comb", cpu_ce, 0);
    @(negedge clk);
    check("reset_run_ce", cpu_ce, 0);
    check("reset_run_halted", halted, 1);
    check("reset_run_cause", halt_cause, CAUSE_RESET);
    check("reset_run_cycle_cnt", cycle_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ce", cpu_ce, 0);

    repeat (2) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Run-control sequencer for pipeline_CPU, replacing manual clock toggling with a free-running clk plus a clock-enable (cpu_ce).
- Accepts halt / single-step / run / run-N commands from the VIO-side debug host.
- Stops the core on an instruction-address breakpoint.
- Exports halt cause, an executed-cycle counter and a PC snapshot for VIO/ILA probing.
- Sits in top between VIO outputs and the CPU.

Parameters:
AW, 32, instruction address width
CW, 16, run-N count width
YW, 32, cycle counter width

Ports:
clk  in  1  system clock; only clock in the block
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command strobe from debug host
cmd_op  in  2  0=HALT, 1=STEP, 2=RUN, 3=RUN_N
cmd_count  in  CW  cycle count for RUN_N
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
bp_en  in  1  breakpoint enable
bp_addr  in  AW  breakpoint address
iaddr  in  AW  current fetch address from CPU
cpu_ce  out  1  CPU clock enable; CPU state advances only on edges where cpu_ce=1
halted  out  1  high in HALTED state
halt_cause  out  2  0=RESET, 1=CMD (halt or step done), 2=BREAK, 3=COUNT
cycle_cnt  out  YW  number of cpu_ce=1 cycles since reset
snap_iaddr  out  AW  iaddr sampled while halted

Behaviour:
- States: HALTED, STEP, RUN, RUNN.
- Reset values:
  - State HALTED; halted=1, halt_cause=0.
  - cycle_cnt=0, snap_iaddr=0, remaining count=0.
  - bp_skip=0.
- cmd_ready: 0 in STEP, 1 in all other states.
- cpu_ce is combinational:
  - STEP: 1, unconditionally; a step executes even at a breakpoint.
  - RUN / RUNN: ~bp_hit.
  - HALTED: 0.
  - Reset has priority: cpu_ce=0 while reset=1.
- bp_hit = bp_en & (iaddr==bp_addr) & ~bp_skip.
- HALTED accepts:
  - STEP: next cycle STEP.
  - RUN: next cycle RUN.
  - RUN_N with cmd_count>0: load remaining=cmd_count, next cycle RUNN.
  - RUN_N with cmd_count=0: stay HALTED, cause=COUNT, no cpu_ce pulse.
  - HALT: stay HALTED, cause=CMD.
- STEP: exactly one cpu_ce cycle, then HALTED with cause=CMD. Accept at T gives cpu_ce=1 at T+1 and halted=1 at T+2.
- RUN: cpu_ce every cycle until a HALT command or bp_hit.
  - HALT accepted at T: cpu_ce still 1 at T; HALTED at T+1, cause=CMD.
  - bp_hit at T: cpu_ce=0 at T, so the breakpointed instruction is not advanced; HALTED at T+1, cause=BREAK.
- RUNN: remaining decrements on each cpu_ce=1 cycle.
  - Transition to HALTED follows the cycle where remaining goes 1→0, cause=COUNT. Exactly N cpu_ce cycles total.
  - A breakpoint stops early with cause=BREAK.
- Commands other than HALT during RUN/RUNN: accepted and dropped, no state change.
- Priority within one cycle: reset > bp_hit > HALT cmd > count expiry.
  - bp_hit suppresses the remaining decrement.
- bp_skip:
  - Set on leaving HALTED via RUN/RUN_N/STEP when halt_cause==BREAK.
  - Cleared after the first cpu_ce=1 cycle.
  - Purpose: resuming from a breakpoint does not immediately re-hit.
- cycle_cnt: +1 on every cpu_ce=1 cycle; saturates at all-ones; cleared only by reset.
- snap_iaddr <= iaddr on every cycle in HALTED. Equals the post-step PC one cycle after halted rises.
- Reset mid-run: next edge forces HALTED, cause=RESET, cpu_ce=0, counters cleared.

Decomposition:
- Package dbg_pkg:
  - cmd_op encodings OP_HALT/OP_STEP/OP_RUN/OP_RUN_N.
  - halt_cause encodings CAUSE_RESET/CMD/BREAK/COUNT.
  - State enum.
- One sub-module, dbg_bp_match: the comparator plus bp_skip register, output bp_hit.
- FSM, counters and snapshot stay in cpu_debug_ctrl.

Test Plan:
- Reset then STEP at T: cpu_ce high at T+1 only; halted=1 at T+2, halt_cause=1, cycle_cnt=1, snap_iaddr=new iaddr at T+3.
- RUN_N cmd_count=5, bp_en=0: exactly 5 cpu_ce cycles, halt_cause=3, cycle_cnt=5. Then RUN_N cmd_count=0: no cpu_ce, halt_cause=3.
- bp_en=1, bp_addr=0x0000_0010, RUN with PC stepping by 4 from 0: cpu_ce=0 when iaddr=0x10, halt_cause=2, snap_iaddr=0x10. Re-issue RUN: iaddr advances past 0x10 and the core keeps running.
- RUN, then HALT at cycle 7 of execution: cpu_ce high through the acceptance cycle, halted next cycle, halt_cause=1, cycle_cnt=7. STEP issued during RUN is ignored.
- RUN_N cmd_count=3 with breakpoint hit on the 3rd fetch: cause=BREAK (not COUNT), 2 cpu_ce cycles counted.
- Assert reset during RUN: next cycle cpu_ce=0, halted=1, halt_cause=0, cycle_cnt=0.
